// File: rtl/wb_arbiter_if.sv
`default_nettype none
// wb_arbiter_if -- requester and bridge signal bundle for wb_arbiter. Rev 1.0
interface wb_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int data_wl = 16,
  parameter int adr_wl  = 16
);
  logic [NREQ-1:0]         req_i;
  logic [NREQ-1:0]         req_we_i;
  logic [NREQ*adr_wl-1:0]  req_addr_i;
  logic [NREQ*data_wl-1:0] req_data_i;
  logic [NREQ-1:0]         gnt_o;
  logic [NREQ-1:0]         done_o;
  logic                    err_o;
  logic [data_wl-1:0]      rdata_o;
  logic                    m_start_o;
  logic                    m_we_o;
  logic [adr_wl-1:0]       m_addr_o;
  logic [data_wl-1:0]      m_data_o;
  logic                    m_busy_i;
  logic                    m_valid_i;
  logic [data_wl-1:0]      m_data_i;

  // Arbiter side: serves the requesters and masters the bridge.
  modport master (
    input  req_i, req_we_i, req_addr_i, req_data_i, m_busy_i, m_valid_i, m_data_i,
    output gnt_o, done_o, err_o, rdata_o, m_start_o, m_we_o, m_addr_o, m_data_o
  );

  modport slave (
    output req_i, req_we_i, req_addr_i, req_data_i, m_busy_i, m_valid_i, m_data_i,
    input  gnt_o, done_o, err_o, rdata_o, m_start_o, m_we_o, m_addr_o, m_data_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// wb_arbiter -- round-robin sharing of one wishbone bridge with a per-transaction watchdog. Rev 1.0
module wb_arbiter #(
  parameter int NREQ    = 4,
  parameter int data_wl = 16,
  parameter int adr_wl  = 16,
  parameter int TIMEOUT = 255
) (
  input wire           clk,
  input wire           a_reset_l,
  wb_arbiter_if.master bus
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [LW-1:0]       r_last, w_last_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic                r_drain, w_drain_nxt;
  logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]     r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [data_wl-1:0]  r_rdata, w_rdata_nxt;
  logic                r_start, w_start_nxt;
  logic                r_we, w_we_nxt;
  logic [adr_wl-1:0]   r_addr, w_addr_nxt;
  logic [data_wl-1:0]  r_data, w_data_nxt;

  logic                w_any;
  logic [LW-1:0]       w_win;
  logic [LW-1:0]       w_cand;

  // Scan downward in offset so the nearest set bit above r_last is the last to overwrite.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_last;
    w_cand = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand = LW'((int'(r_last) + i) % NREQ);
      if (bus.req_i[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_start_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
          w_last_nxt  = w_win;
          w_we_nxt    = bus.req_we_i[w_win];
          w_addr_nxt  = bus.req_addr_i[int'(w_win)*adr_wl +: adr_wl];
          w_data_nxt  = bus.req_data_i[int'(w_win)*data_wl +: data_wl];
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_start_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
        w_drain_nxt = 1'b0;
      end
      S_WAIT: begin
        if (bus.m_valid_i) begin
          w_state_nxt = S_DONE;
          w_rdata_nxt = bus.m_data_i;
          w_err_nxt   = 1'b0;
          w_done_nxt  = NREQ'(1) << r_last;
        end else if (r_cnt == 16'(TIMEOUT)) begin
          // The bridge cycle is abandoned; its eventual result must be waited out.
          w_state_nxt = S_DONE;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_drain_nxt = 1'b1;
          w_done_nxt  = NREQ'(1) << r_last;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = r_drain ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!bus.m_busy_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_state <= S_IDLE;
      r_last  <= LW'(NREQ - 1);
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_start <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_start <= w_start_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.done_o    = r_done;
  assign bus.err_o     = r_err;
  assign bus.rdata_o   = r_rdata;
  assign bus.m_start_o = r_start;
  assign bus.m_we_o    = r_we;
  assign bus.m_addr_o  = r_addr;
  assign bus.m_data_o  = r_data;
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// tb_wb_arbiter -- randomized scoreboard bench for wb_arbiter with a behavioural bridge. Rev 1.0
module tb_wb_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int TO   = 8;
  localparam int BIG  = 1 << 30;

  logic clk = 1'b0;
  logic a_reset_l = 1'b0;

  wb_arbiter_if #(.NREQ(NREQ), .data_wl(DW), .adr_wl(AW)) bus ();

  wb_arbiter #(.NREQ(NREQ), .data_wl(DW), .adr_wl(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .a_reset_l (a_reset_l),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          who;
    logic        err;
    logic [DW-1:0] data;
    int          at;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference state: last winner, first cycle the arbiter is idle, bridge schedule.
  int mlast = NREQ - 1;
  int idle_from = BIG;
  bit rst_prev = 1'b0;
  logic [NREQ-1:0]    p_req = '0;
  logic [NREQ-1:0]    p_we = '0;
  logic [NREQ*AW-1:0] p_addr = '0;
  logic [NREQ*DW-1:0] p_data = '0;
  bit b_act = 1'b0;
  int b_iss = 0;
  int b_lat = 0;
  logic [DW-1:0] b_dat = '0;

  int lat_force = -1;
  bit dat_force_en = 1'b0;
  logic [DW-1:0] dat_force = '0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] r, input int last);
    logic [NREQ-1:0] t;
    for (int i = 1; i <= NREQ; i++) begin
      t = r >> ((last + i) % NREQ);
      if (t[0]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  // Bridge: busy for lat cycles after seeing start, then one valid cycle with busy low.
  always @(posedge clk) begin
    #1;
    if (!a_reset_l || !b_act) begin
      bus.m_busy_i  = 1'b0;
      bus.m_valid_i = 1'b0;
      bus.m_data_i  = DW'($urandom);
    end else begin
      bus.m_busy_i  = (cyc >= b_iss + 1) && (cyc <= b_iss + b_lat);
      bus.m_valid_i = (cyc == b_iss + b_lat + 1);
      bus.m_data_i  = bus.m_valid_i ? b_dat : DW'($urandom);
    end
  end

  // Monitor / scoreboard.
  int w;
  bit fire;
  int lat;
  logic [NREQ-1:0] egnt;
  logic [DW-1:0] d;
  exp_t e;
  always @(negedge clk) begin
    if (!a_reset_l) begin
      chk("reset_outputs", 64'({bus.gnt_o, bus.done_o, bus.err_o, bus.rdata_o,
                                bus.m_start_o, bus.m_we_o, bus.m_addr_o, bus.m_data_o}), 64'(0));
      q.delete();
      mlast = NREQ - 1;
      idle_from = BIG;
      b_act = 1'b0;
      rst_prev = 1'b0;
    end else begin
      if (!rst_prev) idle_from = cyc;
      rst_prev = 1'b1;
      fire = (cyc - 1 >= idle_from) && (p_req != '0);
      egnt = '0;
      w = 0;
      if (fire) begin
        w = rr(p_req, mlast);
        egnt = NREQ'(1) << w;
      end
      chk("gnt", 64'(bus.gnt_o), 64'(egnt));
      chk("start", 64'(bus.m_start_o), 64'(fire));
      if (fire) begin
        chk("cmd", 64'({bus.m_we_o, bus.m_addr_o, bus.m_data_o}),
            64'({p_we[w], p_addr[w*AW +: AW], p_data[w*DW +: DW]}));
        mlast = w;
        if (lat_force >= 0) lat = lat_force;
        else begin
          case ($urandom_range(0, 9))
            7:       lat = TO;
            8, 9:    lat = TO + int'($urandom_range(1, 6));
            default: lat = int'($urandom_range(1, 4));
          endcase
        end
        d = dat_force_en ? dat_force : DW'($urandom);
        b_act = 1'b1;
        b_iss = cyc;
        b_lat = lat;
        b_dat = d;
        if (lat <= TO) begin
          q.push_back('{who: w, err: 1'b0, data: d, at: cyc + lat + 2});
          idle_from = cyc + lat + 3;
        end else begin
          q.push_back('{who: w, err: 1'b1, data: '0, at: cyc + TO + 2});
          idle_from = ((cyc + TO + 3) > (cyc + lat + 1) ? (cyc + TO + 3) : (cyc + lat + 1)) + 1;
        end
      end
      if (bus.done_o != '0 || (q.size() > 0 && q[0].at <= cyc)) begin
        if (q.size() == 0) chk("spurious_done", 64'(bus.done_o), 64'(0));
        else begin
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("done_who", 64'(bus.done_o), 64'(NREQ'(1) << e.who));
          chk("err", 64'(bus.err_o), 64'(e.err));
          chk("rdata", 64'(bus.rdata_o), 64'(e.data));
        end
      end
    end
    if (end_req && !end_ack) begin
      chk("queue_empty", 64'(q.size()), 64'(0));
      end_ack = 1'b1;
    end
    p_req  = bus.req_i;
    p_we   = bus.req_we_i;
    p_addr = bus.req_addr_i;
    p_data = bus.req_data_i;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] dd);
    bus.req_we_i[k] = we;
    bus.req_addr_i[k*AW +: AW] = a;
    bus.req_data_i[k*DW +: DW] = dd;
  endtask

  task automatic wait_gnt(input int k);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.gnt_o[k]) break;
    end
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && cyc > idle_from + 1) break;
      tick();
    end
  endtask

  task automatic run_auto(input int ncyc, input bit hold);
    logic [NREQ-1:0] gprev;
    gprev = '0;
    repeat (ncyc) begin
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_i[k]) begin
          if (gprev[k]) begin
            if (hold || $urandom_range(0, 1) == 1)
              set_cmd(k, 1'($urandom), AW'($urandom), DW'($urandom));
            else
              bus.req_i[k] = 1'b0;
          end else if (!hold && !bus.gnt_o[k] && $urandom_range(0, 15) == 0) begin
            bus.req_i[k] = 1'b0;
          end
        end else if (hold || $urandom_range(0, 3) == 0) begin
          set_cmd(k, 1'($urandom), AW'($urandom), DW'($urandom));
          bus.req_i[k] = 1'b1;
        end
      end
      gprev = bus.gnt_o;
    end
    bus.req_i = '0;
  endtask

  initial begin
    bus.req_i = '0;
    bus.req_we_i = '0;
    bus.req_addr_i = '0;
    bus.req_data_i = '0;
    repeat (3) @(posedge clk);
    #2 a_reset_l = 1'b1;

    // Single read.
    tick();
    lat_force = 1; dat_force_en = 1'b1; dat_force = 16'hBEEF;
    set_cmd(1, 1'b0, 16'h1234, 16'h0000);
    bus.req_i = 4'b0010;
    wait_gnt(1);
    bus.req_i = '0;
    wait_idle();

    // Write from requester 3.
    lat_force = 2; dat_force_en = 1'b0;
    set_cmd(3, 1'b1, 16'h0040, 16'hA5A5);
    bus.req_i = 4'b1000;
    wait_gnt(3);
    bus.req_i = '0;
    wait_idle();

    // Round robin with all requesters held.
    lat_force = 1;
    run_auto(40, 1'b1);
    wait_idle();

    // Timeout with another request pending through the drain.
    lat_force = TO + 4;
    set_cmd(0, 1'b0, 16'h0100, 16'h0000);
    bus.req_i = 4'b0001;
    wait_gnt(0);
    lat_force = 2;
    bus.req_i = 4'b0100;
    set_cmd(2, 1'b0, 16'h0200, 16'h0000);
    wait_gnt(2);
    bus.req_i = '0;
    wait_idle();

    // Valid exactly at the watchdog boundary.
    lat_force = TO;
    set_cmd(2, 1'b0, 16'h0300, 16'h0000);
    bus.req_i = 4'b0100;
    wait_gnt(2);
    bus.req_i = '0;
    wait_idle();

    // Randomized traffic.
    lat_force = -1;
    run_auto(800, 1'b0);
    wait_idle();

    // Reset in the middle of a bus cycle.
    lat_force = TO + 5;
    set_cmd(2, 1'b1, 16'h0400, 16'h1111);
    bus.req_i = 4'b0100;
    wait_gnt(2);
    bus.req_i = '0;
    repeat (2) tick();
    @(posedge clk);
    #2 a_reset_l = 1'b0;
    set_cmd(1, 1'b0, 16'h0500, 16'h0000);
    set_cmd(2, 1'b0, 16'h0600, 16'h0000);
    bus.req_i = 4'b0110;
    repeat (3) @(posedge clk);
    #2 a_reset_l = 1'b1;
    lat_force = 1;
    wait_gnt(1);
    bus.req_i[1] = 1'b0;
    wait_gnt(2);
    bus.req_i = '0;
    wait_idle();

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin scheduler that shares one `wishbone` master bridge among `NREQ` on-chip requesters. It drives the bridge's `start_i`/`addr_i`/`data_i`/`we_i` command port and watches its `busy_o`/`valid_o`/`data_o` response. Completed results are returned to the granted requester. A per-transaction watchdog reports a hung bus cycle.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `data_wl`, 16: data width, equal to the bridge's.
- `adr_wl`, 16: address width, equal to the bridge's.
- `TIMEOUT`, 255: maximum `WAIT` cycles before an error completion, 1..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `a_reset_l`  in  1  asynchronous active-low reset.
- `req_i`  in  NREQ  level request, one bit per requester.
- `req_we_i`  in  NREQ  write enable per requester.
- `req_addr_i`  in  NREQ*adr_wl  flattened addresses; requester k at bits [k*adr_wl +: adr_wl].
- `req_data_i`  in  NREQ*data_wl  flattened write data; same packing rule.
- `gnt_o`  out  NREQ  one-hot, one-cycle pulse when the requester's command is taken.
- `done_o`  out  NREQ  one-hot, one-cycle completion pulse.
- `err_o`  out  1  valid with `done_o`; 1 = timeout.
- `rdata_o`  out  data_wl  read data, valid with `done_o`.
- `m_start_o`  out  1  to bridge `start_i`.
- `m_we_o`  out  1  to bridge `we_i`.
- `m_addr_o`  out  adr_wl  to bridge `addr_i`.
- `m_data_o`  out  data_wl  to bridge `data_i`.
- `m_busy_i`  in  1  from bridge `busy_o`.
- `m_valid_i`  in  1  from bridge `valid_o`.
- `m_data_i`  in  data_wl  from bridge `data_o`.

## Operation
- States:
  - `IDLE`: no transaction.
  - `ISSUE`: command presented to the bridge.
  - `WAIT`: bus cycle in progress.
  - `DONE`: result returned to the requester.
  - `DRAIN`: waiting out a bridge transaction abandoned on timeout.
- All outputs are registered.
- Reset values: every output is 0, state is `IDLE`, the round-robin pointer `last` is NREQ-1, and the watchdog count is 0.
- **`IDLE`:**
  - If any `req_i` bit is set, the winner is the first set bit scanning upward from `last`+1, modulo NREQ.
  - The winner's we/addr/data are latched into `m_*`, `last` becomes the winner index, and the next state is `ISSUE`.
  - Otherwise the block stays in `IDLE`.
- **`ISSUE`** (exactly one cycle):
  - `m_start_o`=1 and `gnt_o[winner]`=1.
  - Next state is `WAIT`, with the count cleared.
  - `m_addr_o`/`m_data_o`/`m_we_o` hold their values until the next `ISSUE`.
- **`WAIT`:**
  - On `m_valid_i`=1: latch `rdata_o`=`m_data_i`, set `err_o`=0, go to `DONE`.
  - Else, if count==TIMEOUT: set `err_o`=1, set `rdata_o`=0, go to `DONE` and mark `drain`.
  - Else: increment the count.
  - `m_valid_i` wins over a timeout in the same cycle.
- **`DONE`** (one cycle):
  - `done_o[winner]`=1.
  - Next state is `DRAIN` if `drain` is marked, else `IDLE`.
- **`DRAIN`:**
  - Stay until `m_busy_i`==0, then go to `IDLE`.
  - The late bridge result is discarded and no grant is made while in `DRAIN`.
- Requester protocol:
  - A requester holds `req_i` and its command fields stable until its `gnt_o` pulse.
  - It may drop `req_i` or present a new command after the pulse.
  - A requester whose `req_i` is still high after `done_o` competes again in the next `IDLE`.
- Dropping `req_i` before grant withdraws the request with no side effect.
- A mid-operation reset aborts immediately to the reset values with no `done_o`. The bridge shares `a_reset_l` and resets with the arbiter.

## Timing
- `IDLE` with `req_i` sampled at edge 0: `ISSUE` (`gnt_o`, `m_start_o`) in cycle 1, `WAIT` from cycle 2.
- The bridge drops `valid_o` in cycle 2 because it registers `start_i` at edge 1. `m_valid_i` is therefore never stale in the first `WAIT` cycle.
- With a zero-wait-state slave acking in cycle 2:
  - `m_valid_i`=1 in cycle 3.
  - `done_o` in cycle 4.
  - Next `ISSUE` no earlier than cycle 6.
  - Minimum spacing is 5 cycles per transaction.
- Timeout: `done_o` with `err_o`=1 occurs TIMEOUT+2 cycles after `ISSUE`.
- Fairness: a continuously requesting requester is served within NREQ transactions.

## Test plan
- **Single read:** `req_i`=4'b0010 with addr 0x1234; slave acks in cycle 2 with 0xBEEF. Expect:
  - `gnt_o`=4'b0010 and `m_addr_o`=0x1234 in cycle 1.
  - `done_o`=4'b0010, `rdata_o`=0xBEEF, `err_o`=0 in cycle 4.
- **Round robin:** `req_i`=4'b1111 held. Expect grant order 0,1,2,3,0, each grant following the previous `done_o` by 2 cycles.
- **Write:** requester 3 has we=1, addr 0x0040, data 0xA5A5. Expect the bridge `wb_we_o`=1, `wb_adr_o`=0x0040, `wb_dat_o`=0xA5A5, and `done_o`[3] with `err_o`=0.
- **Timeout and drain:** TIMEOUT=8 and the slave never acks. Expect:
  - `done_o` with `err_o`=1 ten cycles after `ISSUE`.
  - No `gnt_o` while `m_busy_i`=1.
  - After a late ack, the next pending request is granted and the stale data is never returned.
- **Valid at the timeout boundary:** `m_valid_i` arrives exactly when count==TIMEOUT. Expect `err_o`=0 and real data returned.
- **Reset mid-WAIT:** pull `a_reset_l` low. Expect:
  - All outputs 0 immediately, asynchronously.
  - No `done_o`.
  - After release, the first grant goes to the lowest set `req_i` bit.
